// File: rtl/seq101_word_scheduler.sv
// Word-to-serial scheduler for a shared Mealy "101" overlapping detector: accepts a word,
// shifts it MSB-first into the detector, counts hits and returns the per-word count.
// Optional build macro SEQ101_CARRY_STATE_EN keeps detector state across word boundaries.
module seq101_word_scheduler #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              det_seq_out,
  output logic              det_rst,
  input  logic              det_in,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_hit,
  input  logic              res_ready,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CLR    = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] REPORT = 2'd3;

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);

`ifdef SEQ101_CARRY_STATE_EN
  localparam logic [1:0] START_ST = SHIFT;
`else
  localparam logic [1:0] START_ST = CLR;
`endif

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [WORD_W-1:0] shreg_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]  match_cnt_q;
  logic              det_rst_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (word_valid) state_d = START_ST;
      CLR:     state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == LAST_BIT) state_d = REPORT;
      REPORT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The detector reset is registered so the detector sees a glitch-free pulse.
`ifdef SEQ101_CARRY_STATE_EN
  assign det_rst_d = 1'b1;
`else
  assign det_rst_d = (state_d != CLR);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      det_rst     <= 1'b0;
    end else begin
      state_q <= state_d;
      det_rst <= det_rst_d;
      case (state_q)
        IDLE: begin
          if (word_valid) begin
            shreg_q     <= word_in;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
          end
        end
        SHIFT: begin
          // det_in is Mealy: it reflects the bit presented in this same cycle.
          if (det_in) match_cnt_q <= sat_inc(match_cnt_q);
          shreg_q   <= {shreg_q[WORD_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign word_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign det_seq_out = (state_q == SHIFT) & shreg_q[WORD_W-1];
  assign res_valid   = (state_q == REPORT);
  assign res_count   = res_valid ? match_cnt_q : '0;
  assign res_hit     = res_valid & (|match_cnt_q);

endmodule

// File: tb/tb_seq101_word_scheduler.sv
// Directed bench for seq101_word_scheduler; includes a behavioural model of the
// external Mealy "101" detector driven by det_seq_out/det_rst.
module tb_seq101_word_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_ready;
  logic       det_seq_out;
  logic       det_rst;
  logic       det_in;
  logic       res_valid;
  logic [3:0] res_count;
  logic       res_hit;
  logic       res_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq101_word_scheduler #(.WORD_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .det_seq_out(det_seq_out), .det_rst(det_rst),
    .det_in(det_in), .res_valid(res_valid), .res_count(res_count),
    .res_hit(res_hit), .res_ready(res_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector: 0 = idle, 1 = seen "1", 2 = seen "10"; hit when a 1 arrives in state 2.
  logic [1:0] ds;
  assign det_in = (ds == 2'd2) && det_seq_out;
  always @(posedge clk or negedge det_rst) begin
    if (!det_rst) ds <= 2'd0;
    else begin
      case (ds)
        2'd0:    ds <= det_seq_out ? 2'd1 : 2'd0;
        2'd1:    ds <= det_seq_out ? 2'd1 : 2'd2;
        default: ds <= det_seq_out ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hands a word over, then waits for res_valid while capturing the serial bits.
  task automatic do_word(input logic [7:0] w, output int lat, output logic [7:0] seq,
                         output logic clr_seen);
    int n;
    word_in = w;
    word_valid = 1'b1;
    n = 0;
    while (!word_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    word_valid = 1'b0;
    clr_seen = !det_rst;
    seq = '0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      tick();
      lat++;
      if (lat >= 1 && lat <= 8) seq = {seq[6:0], det_seq_out};
    end
  endtask

  task automatic finish_word(input string tag, input int exp_cnt);
    chk({tag, "_cnt"}, res_count, exp_cnt);
    chk({tag, "_hit"}, res_hit, (exp_cnt != 0));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_vld_drop"}, res_valid, 1'b0);
    chk({tag, "_idle"}, word_ready, 1'b1);
  endtask

  initial begin
    int         lat;
    logic [7:0] seq;
    logic       clr_seen;
    logic       seen;

    rst = 1'b0;
    word_valid = 1'b1;
    word_in = 8'hA5;
    res_ready = 1'b0;
    #12;
    chk("rst_word_ready", word_ready, 1'b1);
    chk("rst_det_rst", det_rst, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_det_seq_out", det_seq_out, 1'b0);
    word_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("post_rst_det_rst", det_rst, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // 1010_1010: three overlapping hits; 9 edges after acceptance = 1 CLR + 8 SHIFT
    // (10 clocks when the acceptance edge itself is counted).
    do_word(8'b1010_1010, lat, seq, clr_seen);
    chk("w1_clr_det_rst_low", clr_seen, 1'b1);
    chk("w1_serial_bits", seq, 8'b1010_1010);
    chk("w1_latency", lat, 9);
    finish_word("w1", 3);

    do_word(8'h00, lat, seq, clr_seen);
    chk("w2_latency", lat, 9);
    finish_word("w2", 0);
    do_word(8'b1110_0101, lat, seq, clr_seen);
    chk("w3_serial_bits", seq, 8'b1110_0101);
    finish_word("w3", 1);

    // A 101 split across the word boundary is not counted when each word is scanned alone.
    do_word(8'b0000_0010, lat, seq, clr_seen);
    finish_word("b2b_a", 0);
    do_word(8'b1000_0000, lat, seq, clr_seen);
    finish_word("b2b_b", 0);

    // Backpressure in REPORT with 1101_0101 (hits at bits 4, 6, 8 -> 3).
    do_word(8'b1101_0101, lat, seq, clr_seen);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_count", res_count, 4'd3);
      chk("bp_word_ready", word_ready, 1'b0);
      chk("bp_det_seq_out", det_seq_out, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_busy", busy, 1'b0);
    chk("bp_release_res_valid", res_valid, 1'b0);

    // Reset while the 4th bit of 1011_0101 is on the wire.
    word_in = 8'b1011_0101;
    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_busy_before", busy, 1'b1);
    chk("mid_bit4", det_seq_out, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_word_ready", word_ready, 1'b1);
    chk("mid_rst_det_rst", det_rst, 1'b0);
    chk("mid_rst_det_seq_out", det_seq_out, 1'b0);
    chk("mid_rst_res_count", res_count, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | res_valid;
    end
    chk("mid_no_result", seen, 1'b0);
    do_word(8'b0000_0101, lat, seq, clr_seen);
    chk("after_rst_latency", lat, 9);
    finish_word("after_rst", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
